// File: rtl/adjust_mode_ctrl.sv
// Front-panel adjust controller: btn_mode walks RUN -> sec..year -> RUN, up/down give step pulses
// with hold-to-repeat, plus a blink enable. Define ADJ_TIMEOUT_EN for the inactivity return to RUN.
module adjust_mode_ctrl #(
  parameter int HOLD_MS   = 500,
  parameter int REPEAT_MS = 100,
  parameter int BLINK_MS  = 250,
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_ms,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [5:0] field_sel,
  output logic       adj_up,
  output logic       adj_down,
  output logic       adj_active,
  output logic       blink
);
  localparam int RPT_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam int BW      = $clog2(BLINK_MS + 1);

  typedef enum logic [2:0] {S_RUN, S_SEC, S_MIN, S_HOUR, S_DAY, S_MON, S_YEAR} state_t;
  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_REPEAT} rpt_t;

  state_t        state, state_nxt;
  rpt_t          rpt, rpt_nxt;
  logic          rpt_dir, rpt_dir_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt, rpt_limit;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          prev_mode, prev_up, prev_down;
  logic [5:0]    field_nxt;
  logic          up_nxt, down_nxt, blink_nxt;
  logic          mode_rise, up_rise, down_rise;
  logic          in_adj, one_held, state_change, step, timeout_hit;

  assign mode_rise = btn_mode & ~prev_mode;
  assign up_rise   = btn_up & ~prev_up;
  assign down_rise = btn_down & ~prev_down;
  assign in_adj    = (state != S_RUN);
  assign one_held  = btn_up ^ btn_down;

`ifdef ADJ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_S + 1);
  logic [TW-1:0] to_cnt, to_nxt;
  assign timeout_hit = in_adj && (to_cnt == TW'(TIMEOUT_S));
`else
  wire unused_tick_1s = tick_1s;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no branch can leave one unassigned and infer a latch.
    state_nxt   = state;
    rpt_nxt     = rpt;
    rpt_dir_nxt = rpt_dir;
    rcnt_nxt    = rcnt;
    bcnt_nxt    = bcnt;
    blink_nxt   = blink;
    up_nxt      = 1'b0;
    down_nxt    = 1'b0;
    field_nxt   = 6'd0;

    if (timeout_hit)    state_nxt = S_RUN;
    else if (mode_rise) state_nxt = (state == S_YEAR) ? S_RUN : state_t'(state + 3'd1);
    state_change = (state_nxt != state);

    // Repeat only runs after an accepted press, so a button held into a field stays silent.
    rpt_limit = (rpt == R_REPEAT) ? RW'(REPEAT_MS) : RW'(HOLD_MS);
    if (!in_adj || state_change || !one_held) begin
      rpt_nxt  = R_IDLE;
      rcnt_nxt = '0;
    end else if (up_rise || down_rise) begin
      up_nxt      = up_rise;
      down_nxt    = down_rise;
      rpt_nxt     = R_HOLD;
      rpt_dir_nxt = up_rise;
      rcnt_nxt    = '0;
    end else if (rpt != R_IDLE) begin
      if (btn_up != rpt_dir) begin
        rpt_nxt  = R_IDLE;
        rcnt_nxt = '0;
      end else if (rcnt == rpt_limit) begin
        up_nxt   = rpt_dir;
        down_nxt = ~rpt_dir;
        rpt_nxt  = R_REPEAT;
        rcnt_nxt = '0;
      end else if (tick_ms) begin
        rcnt_nxt = rcnt + 1'b1;
      end
    end
    step = up_nxt | down_nxt;

    if (!in_adj || state_change || step) begin
      bcnt_nxt  = '0;
      blink_nxt = 1'b0;
    end else if (bcnt == BW'(BLINK_MS)) begin
      bcnt_nxt  = '0;
      blink_nxt = ~blink;
    end else if (tick_ms) begin
      bcnt_nxt = bcnt + 1'b1;
    end

    case (state_nxt)
      S_SEC:   field_nxt = 6'b000001;
      S_MIN:   field_nxt = 6'b000010;
      S_HOUR:  field_nxt = 6'b000100;
      S_DAY:   field_nxt = 6'b001000;
      S_MON:   field_nxt = 6'b010000;
      S_YEAR:  field_nxt = 6'b100000;
      default: field_nxt = 6'b000000;
    endcase

`ifdef ADJ_TIMEOUT_EN
    to_nxt = to_cnt;
    if (!in_adj || timeout_hit || mode_rise || up_rise || down_rise || step) to_nxt = '0;
    else if (tick_1s) to_nxt = to_cnt + 1'b1;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      rpt        <= R_IDLE;
      rpt_dir    <= 1'b0;
      rcnt       <= '0;
      bcnt       <= '0;
      prev_mode  <= 1'b0;
      prev_up    <= 1'b0;
      prev_down  <= 1'b0;
      field_sel  <= 6'd0;
      adj_up     <= 1'b0;
      adj_down   <= 1'b0;
      adj_active <= 1'b0;
      blink      <= 1'b0;
`ifdef ADJ_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      rpt        <= rpt_nxt;
      rpt_dir    <= rpt_dir_nxt;
      rcnt       <= rcnt_nxt;
      bcnt       <= bcnt_nxt;
      prev_mode  <= btn_mode;
      prev_up    <= btn_up;
      prev_down  <= btn_down;
      field_sel  <= field_nxt;
      adj_up     <= up_nxt;
      adj_down   <= down_nxt;
      adj_active <= (state_nxt != S_RUN);
      blink      <= blink_nxt;
`ifdef ADJ_TIMEOUT_EN
      to_cnt     <= to_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_adjust_mode_ctrl.sv
// Scoreboard bench for adjust_mode_ctrl: stimulus pushes expected events (field change or step
// pulse, with the cycle it must appear), a negedge monitor pops and compares every DUT event.
module tb_adjust_mode_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, tick_ms, tick_1s, btn_mode, btn_up, btn_down;
  logic [5:0] field_sel;
  logic       adj_up, adj_down, adj_active, blink;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int cur    = 0;

  typedef struct {
    string      name;
    logic [6:0] st;
    logic       up;
    logic       dn;
    int         at;
  } ev_t;
  ev_t exp_q[$];

  localparam logic [5:0] FIELD [7] = '{6'b000000, 6'b000001, 6'b000010, 6'b000100,
                                       6'b001000, 6'b010000, 6'b100000};

  adjust_mode_ctrl #(.HOLD_MS(5), .REPEAT_MS(2), .BLINK_MS(8), .TIMEOUT_S(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .tick_1s(tick_1s),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .field_sel(field_sel), .adj_up(adj_up), .adj_down(adj_down),
    .adj_active(adj_active), .blink(blink)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  function automatic logic [6:0] st_of(input int idx);
    return {idx != 0, FIELD[idx]};
  endfunction

  task automatic push(input string name, input logic [6:0] st, input logic up, input logic dn,
                      input int lat);
    ev_t e;
    e.name = name; e.st = st; e.up = up; e.dn = dn; e.at = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic press_mode();
    cur = (cur + 1) % 7;
    push("mode_step", st_of(cur), 1'b0, 1'b0, 1);
    btn_mode = 1'b1; cycle();
    btn_mode = 1'b0; cycle();
  endtask

  task automatic pulse_ms();
    tick_ms = 1'b1; cycle();
    tick_ms = 1'b0; cycle();
  endtask

  task automatic pulse_1s();
    tick_1s = 1'b1; cycle();
    tick_1s = 1'b0; cycle();
  endtask

  logic [6:0] last_st = '0;
  always @(negedge clk) begin
    logic [6:0] obs;
    ev_t        e;
    obs = {adj_active, field_sel};
    if (rst_n && (adj_up || adj_down || obs != last_st)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got st=%b up=%b dn=%b at cycle %0d, want no event",
                 obs, adj_up, adj_down, cyc);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.st || adj_up !== e.up || adj_down !== e.dn || cyc != e.at) begin
          errors++;
          $display("FAIL %s: got st=%b up=%b dn=%b cycle %0d, want st=%b up=%b dn=%b cycle %0d",
                   e.name, obs, adj_up, adj_down, cyc, e.st, e.up, e.dn, e.at);
        end
      end
    end
    last_st = obs;
  end

  initial begin
    rst_n = 1'b1; tick_ms = 1'b0; tick_1s = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    #2 rst_n = 1'b0;
    idle(3);
    check("rst_field_sel", field_sel, 0);
    check("rst_adj_up", adj_up, 0);
    check("rst_adj_down", adj_down, 0);
    check("rst_adj_active", adj_active, 0);
    check("rst_blink", blink, 0);
    rst_n = 1'b1;
    idle(2);

    // Full mode walk back to RUN
    for (int i = 0; i < 7; i++) press_mode();

    // MIN: single step, then blink restart after the step
    press_mode();
    press_mode();
    repeat (6) pulse_ms();
    push("up_min", st_of(2), 1'b1, 1'b0, 1);
    btn_up = 1'b1; idle(3);
    btn_up = 1'b0; idle(2);
    repeat (7) pulse_ms();
    check("blink_after_step_low", blink, 0);
    pulse_ms();
    check("blink_toggle", blink, 1);

    // HOUR: hold down, press pulse then repeats after ticks 5, 7, 9, 11
    press_mode();
    push("down_press", st_of(3), 1'b0, 1'b1, 1);
    btn_down = 1'b1; cycle();
    for (int k = 1; k <= 12; k++) begin
      if (k == 5 || k == 7 || k == 9 || k == 11) push("down_repeat", st_of(3), 1'b0, 1'b1, 2);
      pulse_ms();
    end
    btn_down = 1'b0;
    repeat (4) pulse_ms();
    idle(2);

    // DAY: both buttons give nothing; mode with up advances without a step
    press_mode();
    btn_up = 1'b1; btn_down = 1'b1; idle(2);
    repeat (6) pulse_ms();
    btn_up = 1'b0; btn_down = 1'b0; idle(2);
    cur = 5;
    push("mode_over_up", st_of(5), 1'b0, 1'b0, 1);
    btn_mode = 1'b1; btn_up = 1'b1; cycle();
    btn_mode = 1'b0; idle(3);
    repeat (6) pulse_ms();
    btn_up = 1'b0; idle(2);

    // RUN: buttons are ignored
    press_mode();
    press_mode();
    btn_up = 1'b1; idle(2);
    repeat (6) pulse_ms();
    btn_up = 1'b0; btn_down = 1'b1; idle(2);
    btn_down = 1'b0; idle(2);

    // Reset in the middle of a repeat pulse
    press_mode();
    push("up_sec", st_of(1), 1'b1, 1'b0, 1);
    btn_up = 1'b1; cycle();
    repeat (5) pulse_ms();
    check("repeat_live", adj_up, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_field_sel", field_sel, 0);
    check("midrst_adj_up", adj_up, 0);
    check("midrst_adj_down", adj_down, 0);
    check("midrst_adj_active", adj_active, 0);
    check("midrst_blink", blink, 0);
    cur = 0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    // Still holding up while entering SEC: no step and no repeat
    press_mode();
    repeat (7) pulse_ms();
    btn_up = 1'b0; idle(2);
    push("up_after_rst", st_of(1), 1'b1, 1'b0, 1);
    btn_up = 1'b1; idle(2);
    btn_up = 1'b0; idle(2);

`ifdef ADJ_TIMEOUT_EN
    repeat (5) press_mode();
    repeat (2) pulse_1s();
    push("up_year", st_of(6), 1'b1, 1'b0, 1);
    btn_up = 1'b1; cycle();
    btn_up = 1'b0; cycle();
    repeat (2) pulse_1s();
    idle(3);
    cur = 0;
    push("timeout_after_press", st_of(0), 1'b0, 1'b0, 2);
    pulse_1s();
    idle(2);
    repeat (6) press_mode();
    repeat (2) pulse_1s();
    cur = 0;
    push("timeout_idle", st_of(0), 1'b0, 1'b0, 2);
    pulse_1s();
`else
    repeat (5) press_mode();
    repeat (5) pulse_1s();
    press_mode();
`endif

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
